// File: rtl/ebpc_data_packer.sv
// ebpc_data_packer: collects narrow decoded words into PACK-word beats with a
// per-lane keep mask, and rebuilds frame boundaries (last) from the per-frame
// word count supplied alongside the decoder stream.
module ebpc_data_packer #(
  parameter  int DATA_W        = 8,
  parameter  int LOG_MAX_WORDS = 24,
  parameter  int PACK          = 4,
  localparam int OUT_W         = DATA_W * PACK
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [LOG_MAX_WORDS-1:0] num_words_i,
  input  logic                     num_words_vld_i,
  output logic                     num_words_rdy_o,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     vld_i,
  output logic                     rdy_o,
  output logic [OUT_W-1:0]         data_o,
  output logic [PACK-1:0]          keep_o,
  output logic                     last_o,
  output logic                     vld_o,
  input  logic                     rdy_i
);

  localparam int LANE_W = $clog2(PACK);

  typedef enum logic [1:0] {IDLE, FILL, OUT} state_e;

  state_e                   state_q, state_d;
  logic [LOG_MAX_WORDS-1:0] rem_q, rem_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [OUT_W-1:0]         data_q, data_d;
  logic [PACK-1:0]          keep_q, keep_d;
  logic                     last_q, last_d;
  logic                     word_acc;

  // Remaining-word count never wraps below zero.
  function automatic logic [LOG_MAX_WORDS-1:0] dec_sat(input logic [LOG_MAX_WORDS-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  // Handshake strobes decoded from state; forced low while reset is held.
  always_comb begin
    num_words_rdy_o = 1'b0;
    rdy_o           = 1'b0;
    vld_o           = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE:    num_words_rdy_o = 1'b1;
        FILL:    rdy_o = 1'b1;
        // A last beat must drain before the next frame's count is taken,
        // so input is only passed through for non-last beats.
        OUT: begin
          vld_o = 1'b1;
          rdy_o = rdy_i & ~last_q;
        end
        default: ;
      endcase
    end
  end

  assign word_acc = vld_i & rdy_o;

  // Next-state: count capture, lane filling, and beat hand-off.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (num_words_vld_i) begin
          rem_d   = num_words_i;
          lane_d  = '0;
          data_d  = '0;
          keep_d  = '0;
          // An empty frame still produces one empty last beat.
          last_d  = (num_words_i == '0);
          state_d = (num_words_i == '0) ? OUT : FILL;
        end
      end
      FILL: begin
        if (word_acc) begin
          data_d[lane_q*DATA_W +: DATA_W] = data_i;
          keep_d[lane_q] = 1'b1;
          rem_d  = dec_sat(rem_q);
          lane_d = lane_q + LANE_W'(1);
          if (lane_q == LANE_W'(PACK-1) || rem_q == LOG_MAX_WORDS'(1)) begin
            lane_d  = '0;
            last_d  = (rem_q == LOG_MAX_WORDS'(1));
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (rdy_i) begin
          data_d = '0;
          keep_d = '0;
          lane_d = '0;
          last_d = 1'b0;
          if (last_q) begin
            state_d = IDLE;
          end else begin
            state_d = FILL;
            // Word overlapping the beat hand-off starts the next beat.
            if (vld_i) begin
              data_d[DATA_W-1:0] = data_i;
              keep_d[0] = 1'b1;
              rem_d     = dec_sat(rem_q);
              lane_d    = LANE_W'(1);
              if (rem_q == LOG_MAX_WORDS'(1)) begin
                lane_d  = '0;
                last_d  = 1'b1;
                state_d = OUT;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and beat registers; reset discards any partial beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign data_o = data_q;
  assign keep_o = keep_q;
  assign last_o = last_q;

endmodule

// File: tb/tb_ebpc_data_packer.sv
// Bench for ebpc_data_packer: frames are turned into expected beats by a
// chunking model, a driver streams counts and words with optional stalls,
// and a monitor compares every output handshake against the model.
module tb_ebpc_data_packer;

  localparam int DATA_W        = 8;
  localparam int LOG_MAX_WORDS = 24;
  localparam int PACK          = 4;
  localparam int OUT_W         = DATA_W * PACK;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [PACK-1:0]  k;
    logic             l;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst_i;
  logic [LOG_MAX_WORDS-1:0] num_words_i;
  logic                     num_words_vld_i;
  logic                     num_words_rdy_o;
  logic [DATA_W-1:0]        data_i;
  logic                     vld_i;
  logic                     rdy_o;
  logic [OUT_W-1:0]         data_o;
  logic [PACK-1:0]          keep_o;
  logic                     last_o;
  logic                     vld_o;
  logic                     rdy_i;

  ebpc_data_packer #(.DATA_W(DATA_W), .LOG_MAX_WORDS(LOG_MAX_WORDS), .PACK(PACK)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .num_words_i(num_words_i), .num_words_vld_i(num_words_vld_i), .num_words_rdy_o(num_words_rdy_o),
    .data_i(data_i), .vld_i(vld_i), .rdy_o(rdy_o),
    .data_o(data_o), .keep_o(keep_o), .last_o(last_o), .vld_o(vld_o), .rdy_i(rdy_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0]        words_q[$];
  logic [LOG_MAX_WORDS-1:0] cnt_q[$];
  beat_t                    exp_q[$];
  int                       acc_cyc[$];

  int chk_cnt = 0;
  int pass_cnt = 0;
  bit drv_en = 0, chk_en = 0, stall_en = 0;
  bit acc_next = 0;
  int rdy_hold = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: a frame of n words becomes ceil(n/PACK) beats (one empty
  // beat for n=0), lanes filled in order, unused lanes zero, last on the final beat.
  task automatic add_frame(input int n, input bit seq, input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] w[$];
    beat_t b;
    int nb;
    for (int i = 0; i < n; i++) begin
      logic [DATA_W-1:0] x;
      x = seq ? base + DATA_W'(i) : DATA_W'($urandom);
      w.push_back(x);
      words_q.push_back(x);
    end
    cnt_q.push_back(LOG_MAX_WORDS'(n));
    nb = (n == 0) ? 1 : (n + PACK - 1) / PACK;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int j = 0; j < PACK; j++) begin
        if (bi * PACK + j < n) begin
          b.d[j*DATA_W +: DATA_W] = w[bi*PACK + j];
          b.k[j] = 1'b1;
        end
      end
      b.l = (bi == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && (exp_q.size() != 0 || cnt_q.size() != 0 || words_q.size() != 0); i++)
      @(posedge clk);
    check("drain_beats_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  // Monitor: every cycle, compare output handshakes and protocol rules.
  bit    prev_vld = 0, prev_hold = 0, acc_prev = 0;
  beat_t held;
  always @(negedge clk) begin
    #2;
    if (!chk_en) begin
      prev_vld = 0; prev_hold = 0; acc_prev = 0;
    end else begin
      if (prev_hold) begin
        check("hold_vld", 64'(vld_o), 64'd1);
        check("hold_data", 64'({data_o, keep_o, last_o}), 64'({held.d, held.k, held.l}));
      end
      if (vld_o && !last_o) check("rdy_follow", 64'(rdy_o), 64'(rdy_i));
      if (vld_o && last_o)  check("rdy_last", 64'(rdy_o), 64'd0);
      if (num_words_rdy_o)  check("rdy_idle", 64'({rdy_o, vld_o}), 64'd0);
      if (vld_o && !prev_vld) check("latency", 64'(acc_prev), 64'd1);
      if (vld_o && rdy_i) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL beat_extra: got beat %0h keep %0h last %0h expected none", data_o, keep_o, last_o);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 64'(data_o), 64'(e.d));
          check("beat_keep", 64'(keep_o), 64'(e.k));
          check("beat_last", 64'(last_o), 64'(e.l));
        end
      end
      prev_hold = vld_o && !rdy_i;
      held      = '{d: data_o, k: keep_o, l: last_o};
      prev_vld  = vld_o;
      acc_prev  = acc_next;
    end
  end

  initial begin
    int n;
    rst_i = 1; num_words_i = '0; num_words_vld_i = 0; data_i = '0; vld_i = 0; rdy_i = 0;

    // Driver: presents the head of the count and word streams each cycle.
    fork
      forever begin
        @(negedge clk);
        if (!drv_en) begin
          acc_next = 0;
          continue;
        end
        num_words_vld_i = (cnt_q.size() != 0) && (!stall_en || $urandom_range(0, 2) != 0);
        num_words_i     = (cnt_q.size() != 0) ? cnt_q[0] : '0;
        vld_i           = (words_q.size() != 0) && (!stall_en || $urandom_range(0, 3) == 0 || $urandom_range(0, 1) == 1);
        data_i          = (words_q.size() != 0) ? words_q[0] : '0;
        if (rdy_hold > 0) begin
          rdy_i = 0;
          rdy_hold--;
        end else begin
          rdy_i = !stall_en || $urandom_range(0, 2) != 0;
        end
        #1;
        acc_next = 0;
        if (num_words_vld_i && num_words_rdy_o) begin
          void'(cnt_q.pop_front());
          acc_next = 1;
        end
        if (vld_i && rdy_o) begin
          void'(words_q.pop_front());
          acc_cyc.push_back(cyc);
          acc_next = 1;
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 64'({vld_o, keep_o, last_o, rdy_o, num_words_rdy_o}), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    rst_i = 0;
    @(posedge clk); #1;
    check("rst_release_cnt_rdy", 64'(num_words_rdy_o), 64'd1);

    chk_en = 1; drv_en = 1; stall_en = 0;

    // N=8, words 0x01..0x08 back-to-back
    acc_cyc.delete();
    add_frame(8, 1, 8'h01);
    check("pin8_b0_data", 64'(exp_q[0].d), 64'h04030201);
    check("pin8_b0_keep_last", 64'({exp_q[0].k, exp_q[0].l}), 64'b11110);
    check("pin8_b1_data", 64'(exp_q[1].d), 64'h08070605);
    check("pin8_b1_keep_last", 64'({exp_q[1].k, exp_q[1].l}), 64'b11111);
    wait_drain(200);
    check("n8_words_accepted", 64'(acc_cyc.size()), 64'd8);
    if (acc_cyc.size() == 8) check("n8_consecutive", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);

    // N=5: second beat holds one word
    add_frame(5, 1, 8'h11);
    check("pin5_b0_data", 64'(exp_q[0].d), 64'h14131211);
    check("pin5_b1_data", 64'(exp_q[1].d), 64'h00000015);
    check("pin5_b1_keep_last", 64'({exp_q[1].k, exp_q[1].l}), 64'b00011);
    wait_drain(200);

    // N=0 then N=1 with 0xAA
    add_frame(0, 1, 8'h00);
    add_frame(1, 1, 8'hAA);
    check("pin0_beat", 64'({exp_q[0].d, exp_q[0].k, exp_q[0].l}), 64'h1);
    check("pin1_data", 64'(exp_q[1].d), 64'h000000AA);
    check("pin1_keep_last", 64'({exp_q[1].k, exp_q[1].l}), 64'b00011);
    wait_drain(200);

    // Backpressure: rdy_i low for 10 cycles once the first beat is valid
    add_frame(8, 1, 8'h21);
    for (int i = 0; i < 50 && !vld_o; i++) begin
      @(posedge clk); #1;
    end
    check("bp_first_valid", 64'(vld_o), 64'd1);
    rdy_hold = 10;
    wait_drain(300);

    // Reset after 3 words of an N=8 frame
    acc_cyc.delete();
    cnt_q.push_back(LOG_MAX_WORDS'(8));
    for (int i = 0; i < 8; i++) words_q.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 50 && acc_cyc.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    check("rstmid_three_words", 64'(acc_cyc.size()), 64'd3);
    drv_en = 0; chk_en = 0;
    rst_i = 1; vld_i = 0; num_words_vld_i = 0; rdy_i = 1;
    words_q.delete(); cnt_q.delete();
    @(posedge clk); #1;
    check("rstmid_outputs", 64'({vld_o, keep_o, last_o, rdy_o, num_words_rdy_o}), 64'd0);
    check("rstmid_data", 64'(data_o), 64'd0);
    @(posedge clk); #1;
    check("rstmid_no_beat", 64'(vld_o), 64'd0);
    rst_i = 0;
    @(posedge clk); #1;
    check("rstmid_cnt_rdy", 64'({num_words_rdy_o, vld_o}), 64'b10);
    chk_en = 1; drv_en = 1;
    add_frame(4, 1, 8'h41);
    check("pin4_beat", 64'({exp_q[0].d, exp_q[0].k, exp_q[0].l}), {27'd0, 32'h44434241, 4'hF, 1'b1});
    wait_drain(200);

    // Random frames with random input/output stalls
    stall_en = 1;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 20);
      add_frame(n, 0, 8'h00);
    end
    wait_drain(6000);

    drv_en = 0; chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
